// File: rtl/chnl_host_pkg.sv
// -----------------------------------------------------------------------------
// chnl_host_pkg
// Shared definitions for the RIFFA host-side channel emulator:
//   state_t        - transaction state machine encoding
//   WDOG_W         - watchdog counter width (used when CHNL_HOST_TIMEOUT_EN)
//   ERR_SAT        - saturation value of the error counter
//   wpb()          - 32-bit words per data beat for a given bus width
//   beats_for_len()- number of beats needed to carry a length in words
// -----------------------------------------------------------------------------
package chnl_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_REQ,
        ST_RX_DATA,
        ST_TX_WAIT,
        ST_TX_ACK,
        ST_TX_DATA,
        ST_FINISH
    } state_t;

    localparam int         WDOG_W  = 16;
    localparam logic [7:0] ERR_SAT = 8'hFF;

    function automatic int unsigned wpb(input int unsigned data_width);
        return data_width / 32;
    endfunction

    // Ceiling division; the bus width is a power of two so this folds to a shift.
    function automatic logic [31:0] beats_for_len(input logic [31:0] len,
                                                  input int unsigned words_per_beat);
        logic [31:0] q;
        q = len / words_per_beat;
        if ((len % words_per_beat) != 0)
            q = q + 32'd1;
        return q;
    endfunction

endpackage

// File: rtl/chnl_host_emu_pattern.sv
// -----------------------------------------------------------------------------
// chnl_pattern_gen
// Arithmetic pattern generator. On i_load it latches start/step/direction; on
// each i_adv the current word moves by +/- step (mod 2^32). o_word is the
// current word plus a fixed offset.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_load                latch i_start/i_step/i_dec
//   i_start, i_step       first word, increment magnitude
//   i_dec                 1 = descending sequence
//   i_adv                 step to the next word
//   o_word                current word + P_OFFSET
// -----------------------------------------------------------------------------
module chnl_pattern_gen #(
    parameter logic [31:0] P_OFFSET = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_start,
    input  logic [31:0] i_step,
    input  logic        i_dec,
    input  logic        i_adv,
    output logic [31:0] o_word
);

    logic [31:0] r_word;
    logic [31:0] r_step;
    logic        r_dec;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word <= '0;
            r_step <= '0;
            r_dec  <= 1'b0;
        end else if (i_load) begin
            r_word <= i_start;
            r_step <= i_step;
            r_dec  <= i_dec;
        end else if (i_adv) begin
            r_word <= r_dec ? (r_word - r_step) : (r_word + r_step);
        end
    end

    assign o_word = r_word + P_OFFSET;

endmodule

// File: rtl/chnl_host_emu.sv
// -----------------------------------------------------------------------------
// chnl_host_emu
// Host-side emulator for a RIFFA channel. Pushes a generated pattern into the
// user engine (RX), accepts the engine's transmit (TX), and checks each
// returned word against pattern + EXP_OFFSET.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   START, PAT_*             one-cycle run request and pattern setup
//   CHNL_RX*                 RX transfer request/data toward the engine
//   CHNL_TX*                 TX request/data from the engine
//   BUSY, DONE, PASS         transaction status
//   ERR_CNT                  mismatched or extra beats (saturating)
//   TX_LEN_CAP               CHNL_TX_LEN captured at the TX request
//   TIMEOUT                  watchdog expiry (only with CHNL_HOST_TIMEOUT_EN)
// Build option: define CHNL_HOST_TIMEOUT_EN to add a 16-bit watchdog.
// -----------------------------------------------------------------------------
module chnl_host_emu
    import chnl_host_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 128,
    parameter int BUFF_SIZE        = 10,
    parameter int EXP_OFFSET       = 3
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        START,
    input  logic [31:0]                 PAT_START,
    input  logic [31:0]                 PAT_STEP,
    input  logic                        PAT_DEC,
    output logic                        CHNL_RX,
    input  logic                        CHNL_RX_ACK,
    output logic                        CHNL_RX_LAST,
    output logic [31:0]                 CHNL_RX_LEN,
    output logic [30:0]                 CHNL_RX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    output logic                        CHNL_RX_DATA_VALID,
    input  logic                        CHNL_RX_DATA_REN,
    input  logic                        CHNL_TX,
    output logic                        CHNL_TX_ACK,
    input  logic                        CHNL_TX_LAST,
    input  logic [31:0]                 CHNL_TX_LEN,
    input  logic [30:0]                 CHNL_TX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    input  logic                        CHNL_TX_DATA_VALID,
    output logic                        CHNL_TX_DATA_REN,
`ifdef CHNL_HOST_TIMEOUT_EN
    output logic                        TIMEOUT,
`endif
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        PASS,
    output logic [7:0]                  ERR_CNT,
    output logic [31:0]                 TX_LEN_CAP
);

    localparam int unsigned WPB    = wpb(C_PCI_DATA_WIDTH);
    localparam logic [31:0] RX_LEN = 32'(BUFF_SIZE * WPB);
    localparam logic [31:0] BUFF_N = 32'(BUFF_SIZE);

    state_t                      r_state;
    logic                        r_rx;
    logic                        r_rx_last;
    logic [31:0]                 r_rx_len;
    logic [C_PCI_DATA_WIDTH-1:0] r_rx_data;
    logic                        r_rx_valid;
    logic                        r_tx_ack;
    logic                        r_tx_ren;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_pass;
    logic [7:0]                  r_err_cnt;
    logic [31:0]                 r_tx_len_cap;
    logic [31:0]                 r_rx_cnt;
    logic [31:0]                 r_tx_cnt;
    logic [31:0]                 r_nb;
    logic                        r_timeout;

    logic        w_start;
    logic        w_rx_xfer;
    logic        w_tx_xfer;
    logic        w_rx_adv;
    logic        w_beat_bad;
    logic [31:0] w_rx_word;
    logic [31:0] w_tx_exp;
    logic        w_unused;

    assign w_start   = (r_state == ST_IDLE) && START;
    assign w_rx_xfer = r_rx_valid && CHNL_RX_DATA_REN;
    assign w_tx_xfer = r_tx_ren && CHNL_TX_DATA_VALID;
    // The RX generator runs one word ahead of CHNL_RX_DATA: word 0 is loaded
    // into the data register on ACK, so the generator moves on at that point.
    assign w_rx_adv  = ((r_state == ST_RX_REQ) && CHNL_RX_ACK) || w_rx_xfer;
    assign w_beat_bad = (r_tx_cnt >= BUFF_N) ||
                        (CHNL_TX_DATA != C_PCI_DATA_WIDTH'(w_tx_exp));
    assign w_unused  = &{1'b0, CHNL_TX_LAST, CHNL_TX_OFF};

    chnl_pattern_gen #(.P_OFFSET(32'd0)) u_rx_gen (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_load  (w_start),
        .i_start (PAT_START),
        .i_step  (PAT_STEP),
        .i_dec   (PAT_DEC),
        .i_adv   (w_rx_adv),
        .o_word  (w_rx_word)
    );

    chnl_pattern_gen #(.P_OFFSET(32'(EXP_OFFSET))) u_tx_gen (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_load  (w_start),
        .i_start (PAT_START),
        .i_step  (PAT_STEP),
        .i_dec   (PAT_DEC),
        .i_adv   (w_tx_xfer),
        .o_word  (w_tx_exp)
    );

`ifdef CHNL_HOST_TIMEOUT_EN
    logic [WDOG_W-1:0] r_wdog;
    logic              w_watched;
    logic              w_progress;

    always_comb begin
        w_watched  = 1'b0;
        w_progress = 1'b0;
        case (r_state)
            ST_RX_REQ:  begin w_watched = 1'b1; w_progress = CHNL_RX_ACK; end
            ST_RX_DATA: begin w_watched = 1'b1; w_progress = w_rx_xfer; end
            ST_TX_WAIT: begin w_watched = 1'b1; w_progress = CHNL_TX; end
            ST_TX_DATA: begin w_watched = 1'b1; w_progress = w_tx_xfer || (r_tx_cnt == r_nb); end
            default:    ;
        endcase
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_rx         <= 1'b0;
            r_rx_last    <= 1'b0;
            r_rx_len     <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_tx_ack     <= 1'b0;
            r_tx_ren     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_tx_len_cap <= '0;
            r_rx_cnt     <= '0;
            r_tx_cnt     <= '0;
            r_nb         <= '0;
            r_timeout    <= 1'b0;
`ifdef CHNL_HOST_TIMEOUT_EN
            r_wdog       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_state   <= ST_RX_REQ;
                        r_busy    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_err_cnt <= '0;
                        r_timeout <= 1'b0;
                        r_rx      <= 1'b1;
                        r_rx_last <= 1'b1;
                        r_rx_len  <= RX_LEN;
                        r_rx_cnt  <= '0;
                        r_tx_cnt  <= '0;
                        r_nb      <= '0;
                    end
                end
                ST_RX_REQ: begin
                    if (CHNL_RX_ACK) begin
                        r_state    <= ST_RX_DATA;
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= C_PCI_DATA_WIDTH'(w_rx_word);
                    end
                end
                ST_RX_DATA: begin
                    if (w_rx_xfer) begin
                        if (r_rx_cnt == BUFF_N - 32'd1) begin
                            r_state    <= ST_TX_WAIT;
                            r_rx       <= 1'b0;
                            r_rx_last  <= 1'b0;
                            r_rx_len   <= '0;
                            r_rx_data  <= '0;
                            r_rx_valid <= 1'b0;
                        end else begin
                            r_rx_cnt  <= r_rx_cnt + 32'd1;
                            r_rx_data <= C_PCI_DATA_WIDTH'(w_rx_word);
                        end
                    end
                end
                ST_TX_WAIT: begin
                    if (CHNL_TX) begin
                        r_state      <= ST_TX_ACK;
                        r_tx_len_cap <= CHNL_TX_LEN;
                        r_nb         <= beats_for_len(CHNL_TX_LEN, WPB);
                        r_tx_ack     <= 1'b1;
                    end
                end
                ST_TX_ACK: begin
                    r_state  <= ST_TX_DATA;
                    r_tx_ack <= 1'b0;
                    r_tx_ren <= (r_nb != '0);
                end
                ST_TX_DATA: begin
                    if (r_tx_cnt == r_nb) begin
                        // Only reachable with an empty data phase.
                        r_state  <= ST_FINISH;
                        r_tx_ren <= 1'b0;
                    end else if (w_tx_xfer) begin
                        if (w_beat_bad && (r_err_cnt != ERR_SAT))
                            r_err_cnt <= r_err_cnt + 8'd1;
                        r_tx_cnt <= r_tx_cnt + 32'd1;
                        if (r_tx_cnt + 32'd1 == r_nb) begin
                            r_state  <= ST_FINISH;
                            r_tx_ren <= 1'b0;
                        end
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (r_err_cnt == '0) && (r_nb == BUFF_N) && !r_timeout;
                end
                default: r_state <= ST_IDLE;
            endcase

`ifdef CHNL_HOST_TIMEOUT_EN
            // NOTE: these assignments come after the case so that, being the
            // last non-blocking write to each register, they win over it.
            if (w_watched && (r_wdog == '1)) begin
                r_state    <= ST_FINISH;
                r_timeout  <= 1'b1;
                r_rx       <= 1'b0;
                r_rx_last  <= 1'b0;
                r_rx_len   <= '0;
                r_rx_data  <= '0;
                r_rx_valid <= 1'b0;
                r_tx_ren   <= 1'b0;
                r_wdog     <= '0;
            end else if (w_watched && !w_progress) begin
                r_wdog <= r_wdog + 1'b1;
            end else begin
                r_wdog <= '0;
            end
`endif
        end
    end

    assign CHNL_RX            = r_rx;
    assign CHNL_RX_LAST       = r_rx_last;
    assign CHNL_RX_LEN        = r_rx_len;
    assign CHNL_RX_OFF        = '0;
    assign CHNL_RX_DATA       = r_rx_data;
    assign CHNL_RX_DATA_VALID = r_rx_valid;
    assign CHNL_TX_ACK        = r_tx_ack;
    assign CHNL_TX_DATA_REN   = r_tx_ren;
    assign BUSY               = r_busy;
    assign DONE               = r_done;
    assign PASS               = r_pass;
    assign ERR_CNT            = r_err_cnt;
    assign TX_LEN_CAP         = r_tx_len_cap;
`ifdef CHNL_HOST_TIMEOUT_EN
    assign TIMEOUT            = r_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = r_timeout;
`endif

endmodule

// File: tb/tb_chnl_host_emu.sv
// -----------------------------------------------------------------------------
// tb_chnl_host_emu
// Loopback engine around chnl_host_emu: accepts the RX pattern, requests a TX
// of a chosen length and returns (possibly corrupted) data. Expected values
// come from a closed-form pattern model: word k = start +/- k*step.
// -----------------------------------------------------------------------------
module tb_chnl_host_emu;

    localparam int DW    = 128;
    localparam int BUFF  = 10;
    localparam int OFFS  = 3;
    localparam int WPB_L = DW / 32;
    localparam int RXLEN = BUFF * WPB_L;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [31:0]   PAT_START = '0;
    logic [31:0]   PAT_STEP = '0;
    logic          PAT_DEC = 1'b0;
    logic          CHNL_RX;
    logic          CHNL_RX_ACK = 1'b0;
    logic          CHNL_RX_LAST;
    logic [31:0]   CHNL_RX_LEN;
    logic [30:0]   CHNL_RX_OFF;
    logic [DW-1:0] CHNL_RX_DATA;
    logic          CHNL_RX_DATA_VALID;
    logic          CHNL_RX_DATA_REN = 1'b0;
    logic          CHNL_TX = 1'b0;
    logic          CHNL_TX_ACK;
    logic          CHNL_TX_LAST = 1'b0;
    logic [31:0]   CHNL_TX_LEN = '0;
    logic [30:0]   CHNL_TX_OFF = '0;
    logic [DW-1:0] CHNL_TX_DATA = '0;
    logic          CHNL_TX_DATA_VALID = 1'b0;
    logic          CHNL_TX_DATA_REN;
    logic          BUSY;
    logic          DONE;
    logic          PASS;
    logic [7:0]    ERR_CNT;
    logic [31:0]   TX_LEN_CAP;
`ifdef CHNL_HOST_TIMEOUT_EN
    logic          TIMEOUT;
`endif

    always #5 CLK = ~CLK;

    chnl_host_emu #(.C_PCI_DATA_WIDTH(DW), .BUFF_SIZE(BUFF), .EXP_OFFSET(OFFS)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .PAT_START(PAT_START), .PAT_STEP(PAT_STEP), .PAT_DEC(PAT_DEC),
        .CHNL_RX(CHNL_RX), .CHNL_RX_ACK(CHNL_RX_ACK), .CHNL_RX_LAST(CHNL_RX_LAST),
        .CHNL_RX_LEN(CHNL_RX_LEN), .CHNL_RX_OFF(CHNL_RX_OFF), .CHNL_RX_DATA(CHNL_RX_DATA),
        .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID), .CHNL_RX_DATA_REN(CHNL_RX_DATA_REN),
        .CHNL_TX(CHNL_TX), .CHNL_TX_ACK(CHNL_TX_ACK), .CHNL_TX_LAST(CHNL_TX_LAST),
        .CHNL_TX_LEN(CHNL_TX_LEN), .CHNL_TX_OFF(CHNL_TX_OFF), .CHNL_TX_DATA(CHNL_TX_DATA),
        .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID), .CHNL_TX_DATA_REN(CHNL_TX_DATA_REN),
`ifdef CHNL_HOST_TIMEOUT_EN
        .TIMEOUT(TIMEOUT),
`endif
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT), .TX_LEN_CAP(TX_LEN_CAP)
    );

    typedef struct {
        logic [31:0] start;
        logic [31:0] step;
        logic        dec;
        logic [31:0] tx_len;
        int          corrupt;   // TX beat returned as 0, -1 = none
        bit          rx_stall;  // REN low every other RX beat
        bit          tx_gaps;   // random VALID drops on TX
        int          rst_at;    // RST asserted at this TX beat, -1 = none
        bit          poke;      // extra START pulse while busy
        bit          no_tx;     // engine never requests TX
        bit          has_exp;
        bit          exp_pass;
        int          exp_err;
    } txn_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input txn_t t, input int k);
        logic [31:0] m;
        m = t.step * 32'(k);
        return t.dec ? (t.start - m) : (t.start + m);
    endfunction

    function automatic txn_t mk(input logic [31:0] s, input logic [31:0] st, input logic d,
                                input logic [31:0] len, input bit ep, input int ee);
        txn_t t;
        t.start = s; t.step = st; t.dec = d; t.tx_len = len;
        t.corrupt = -1; t.rx_stall = 1'b0; t.tx_gaps = 1'b0; t.rst_at = -1;
        t.poke = 1'b0; t.no_tx = 1'b0; t.has_exp = 1'b1; t.exp_pass = ep; t.exp_err = ee;
        return t;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_pass"}, PASS, 0);
        check({tag, "_err"}, ERR_CNT, 0);
        check({tag, "_lencap"}, TX_LEN_CAP, 0);
        check({tag, "_rx"}, {CHNL_RX, CHNL_RX_LAST, CHNL_RX_DATA_VALID}, 0);
        check({tag, "_rxlen"}, CHNL_RX_LEN, 0);
        check({tag, "_rxdata"}, CHNL_RX_DATA, 0);
        check({tag, "_tx"}, {CHNL_TX_ACK, CHNL_TX_DATA_REN}, 0);
    endtask

    task automatic run_txn(input txn_t t);
        int          k, j, nb, cyc, exp_err;
        bit          stalled, stall, poked, gap, exp_pass;
        logic [DW-1:0] held;
        logic [31:0] d;
        logic [31:0] ret[$];

        @(negedge CLK);
        PAT_START = t.start; PAT_STEP = t.step; PAT_DEC = t.dec; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("busy_after_start", BUSY, 1);
        check("rx_req", {CHNL_RX, CHNL_RX_LAST, CHNL_RX_DATA_VALID}, 3'b110);
        check("rx_len", CHNL_RX_LEN, RXLEN);
        check("rx_off", CHNL_RX_OFF, 0);
`ifdef CHNL_HOST_TIMEOUT_EN
        check("timeout_cleared", TIMEOUT, 0);
`endif
        @(negedge CLK);
        CHNL_RX_ACK = 1'b1;
        @(negedge CLK);
        CHNL_RX_ACK = 1'b0;

        // RX data phase
        k = 0; cyc = 0; stalled = 1'b0; poked = 1'b0; held = '0;
        while (k < BUFF) begin
            START = 1'b0;
            if (t.poke && k == 3 && !poked) begin
                START = 1'b1; PAT_START = ~t.start; poked = 1'b1;
            end
            if (CHNL_RX_DATA_VALID) begin
                if (stalled) check("rx_hold", CHNL_RX_DATA, held);
                stall = t.rx_stall && !stalled;
                CHNL_RX_DATA_REN = !stall;
                if (!stall) begin
                    check("rx_data", CHNL_RX_DATA, DW'(pat(t, k)));
                    k++;
                end
                held = CHNL_RX_DATA;
                stalled = stall;
            end else begin
                CHNL_RX_DATA_REN = 1'b0;
            end
            cyc++;
            if (cyc > 200) begin
                check("rx_phase_bound", 0, 1);
                CHNL_RX_DATA_REN = 1'b0;
                return;
            end
            @(negedge CLK);
        end
        CHNL_RX_DATA_REN = 1'b0;
        START = 1'b0;
        check("rx_end_ctrl", {CHNL_RX, CHNL_RX_LAST, CHNL_RX_DATA_VALID}, 0);
        check("rx_end_len", CHNL_RX_LEN, 0);
        check("rx_end_data", CHNL_RX_DATA, 0);
        check("busy_mid", BUSY, 1);

        if (t.no_tx) begin
`ifdef CHNL_HOST_TIMEOUT_EN
            cyc = 0;
            while (!DONE && cyc < 70000) begin
                @(negedge CLK); cyc++;
            end
            check("timeout_done", DONE, 1);
            check("timeout_flag", TIMEOUT, 1);
            check("timeout_pass", PASS, 0);
            check("timeout_busy", BUSY, 0);
            check("timeout_min_wait", (cyc >= 65535) ? 1 : 0, 1);
`endif
            return;
        end

        // TX request and acknowledge
        CHNL_TX = 1'b1; CHNL_TX_LEN = t.tx_len; CHNL_TX_LAST = 1'b1;
        cyc = 0;
        do begin
            @(negedge CLK); cyc++;
        end while (!CHNL_TX_ACK && cyc < 50);
        check("tx_ack_seen", CHNL_TX_ACK, 1);
        CHNL_TX = 1'b0; CHNL_TX_LAST = 1'b0;
        @(negedge CLK);
        check("tx_ack_one_cycle", CHNL_TX_ACK, 0);
        check("tx_len_cap", TX_LEN_CAP, t.tx_len);

        // TX data phase
        nb = int'((64'(t.tx_len) + 64'(WPB_L - 1)) / 64'(WPB_L));
        j = 0; cyc = 0;
        while (j < nb) begin
            if (t.rst_at == j) begin
                RST = 1'b1; CHNL_TX_DATA_VALID = 1'b0; CHNL_TX_DATA = '0;
                @(negedge CLK);
                @(negedge CLK);
                check_all_zero("mid_rst");
                RST = 1'b0;
                return;
            end
            gap = t.tx_gaps && ($urandom_range(0, 2) == 0);
            if (CHNL_TX_DATA_REN && !gap) begin
                d = (j < BUFF) ? pat(t, j) + 32'(OFFS) : (32'h5555_5555 ^ 32'(j));
                if (j == t.corrupt) d = '0;
                CHNL_TX_DATA = DW'(d);
                CHNL_TX_DATA_VALID = 1'b1;
                ret.push_back(d);
                j++;
            end else begin
                CHNL_TX_DATA_VALID = 1'b0;
            end
            @(negedge CLK);
            cyc++;
            if (cyc > 2000) begin
                check("tx_phase_bound", 0, 1);
                break;
            end
        end
        CHNL_TX_DATA_VALID = 1'b0; CHNL_TX_DATA = '0;
        check("tx_ren_drop", CHNL_TX_DATA_REN, 0);

        // Reference: every beat beyond BUFF or differing from pattern+offset is an error.
        exp_err = 0;
        foreach (ret[i])
            if (i >= BUFF || ret[i] != pat(t, i) + 32'(OFFS)) exp_err++;
        if (exp_err > 255) exp_err = 255;
        exp_pass = (exp_err == 0) && (nb == BUFF);
        if (t.has_exp) begin
            exp_err = t.exp_err;
            exp_pass = t.exp_pass;
        end

        cyc = 0;
        while (!DONE && cyc < 20) begin
            @(negedge CLK); cyc++;
        end
        check("done_seen", DONE, 1);
        check("pass", PASS, exp_pass);
        check("err_cnt", ERR_CNT, exp_err);
        check("busy_end", BUSY, 0);
        @(negedge CLK);
        check("done_one_pulse", DONE, 0);
        check("pass_held", PASS, exp_pass);
    endtask

    txn_t tbl[10];
    txn_t t;
    logic [31:0] lens[8] = '{32'd40, 32'd37, 32'd33, 32'd44, 32'd0, 32'd8, 32'd40, 32'd40};

    initial begin
        tbl[0] = mk(32'd100, 32'd10, 1'b1, 32'd40, 1'b1, 0);
        tbl[1] = mk(32'd1, 32'd1, 1'b0, 32'd40, 1'b1, 0);   tbl[1].tx_gaps = 1'b1;
        tbl[2] = mk(32'd1, 32'd1, 1'b0, 32'd40, 1'b0, 1);   tbl[2].corrupt = 5;
        tbl[3] = mk(32'd100, 32'd10, 1'b1, 32'd48, 1'b0, 2);
        tbl[4] = mk(32'd20, 32'd2, 1'b0, 32'd40, 1'b0, 0);  tbl[4].rx_stall = 1'b1; tbl[4].rst_at = 4;
        tbl[5] = mk(32'd7, 32'd3, 1'b0, 32'd40, 1'b1, 0);   tbl[5].rx_stall = 1'b1; tbl[5].poke = 1'b1;
        tbl[6] = mk(32'd9, 32'd4, 1'b1, 32'd37, 1'b1, 0);
        tbl[7] = mk(32'd9, 32'd4, 1'b0, 32'd0, 1'b0, 0);
        tbl[8] = mk(32'd2, 32'd5, 1'b0, 32'd1100, 1'b0, 255);
        tbl[9] = mk(32'd5, 32'd10, 1'b1, 32'd40, 1'b1, 0);

        repeat (3) @(negedge CLK);
        check_all_zero("in_reset");
        RST = 1'b0;
        @(negedge CLK);
        check_all_zero("after_reset");

        for (int i = 0; i < 10; i++)
            run_txn(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            t = mk($urandom, $urandom_range(0, 1000), 1'($urandom_range(0, 1)),
                   lens[$urandom_range(0, 7)], 1'b0, 0);
            t.has_exp  = 1'b0;
            t.corrupt  = $urandom_range(0, 1) ? int'($urandom_range(0, 9)) : -1;
            t.rx_stall = 1'($urandom_range(0, 1));
            t.tx_gaps  = 1'($urandom_range(0, 1));
            run_txn(t);
        end

`ifdef CHNL_HOST_TIMEOUT_EN
        t = mk(32'd1, 32'd1, 1'b0, 32'd40, 1'b0, 0);
        t.no_tx = 1'b1;
        run_txn(t);
        run_txn(mk(32'd1, 32'd1, 1'b0, 32'd40, 1'b1, 0));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
